// File: rtl/tlb_pkg.sv
// Shared types and constants for the CP0 TLB register block: packed TLB entry
// layout, CP0 register numbers and the TLBP/TLBR sequencer states.
package tlb_pkg;

  typedef struct packed {
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d;
    logic        v;
  } tlb_page_t;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    tlb_page_t   p0;
    tlb_page_t   p1;
    logic [7:0]  pad;
  } tlb_entry_t;

  localparam logic [4:0] CP0_INDEX    = 5'd0;
  localparam logic [4:0] CP0_RANDOM   = 5'd1;
  localparam logic [4:0] CP0_ENTRYLO0 = 5'd2;
  localparam logic [4:0] CP0_ENTRYLO1 = 5'd3;
  localparam logic [4:0] CP0_WIRED    = 5'd6;
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ENTRYHI  = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_READ  = 2'd2
  } tlb_fsm_e;

endpackage

// File: rtl/cp0_random_counter.sv
// Random/Wired pair: Random walks down from RANDOM_RESET to Wired (or 0) and
// wraps, so TLBWR never lands on a wired entry.
module cp0_random_counter #(
  parameter int IDX_W        = 4,
  parameter int RANDOM_RESET = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] wired_wdata,
  output logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] RAND_INIT = IDX_W'(RANDOM_RESET);

  always_ff @(posedge clk) begin
    if (rst) begin
      wired  <= '0;
      random <= RAND_INIT;
    end else if (wired_we) begin
      wired  <= wired_wdata;
      random <= RAND_INIT;
    end else if (random == wired || random == '0) begin
      random <= RAND_INIT;
    end else begin
      random <= random - IDX_W'(1);
    end
  end

endmodule

// File: rtl/cp0_tlb_regs.sv
// CP0 TLB management registers: software access, TLBP/TLBR sequencing and
// exception-time loading of EntryHi/BadVAddr, feeding the TLB array.
module cp0_tlb_regs
  import tlb_pkg::*;
#(
  parameter int TLB_ENTRIES  = 16,
  parameter int IDX_W        = $clog2(TLB_ENTRIES),
  parameter int RANDOM_RESET = TLB_ENTRIES - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mtc0_en,
  input  logic [4:0]       mtc0_addr,
  input  logic [31:0]      mtc0_data,
  input  logic [4:0]       mfc0_addr,
  output logic [31:0]      mfc0_data,
  input  logic             tlbp_req,
  input  logic             tlbr_req,
  input  logic             tlbwi_req,
  input  logic             tlbwr_req,
  output logic             busy,
  output logic             done,
  input  logic             tlb_exc,
  input  logic [31:0]      tlb_exc_vaddr,
  output logic             tlbp,
  output logic             tlbwi,
  output logic             tlbwr,
  output logic [7:0]       curr_ASID,
  output logic [IDX_W-1:0] cp0_index,
  output logic [IDX_W-1:0] cp0_random,
  output logic [85:0]      cp0_tlb_conf_in,
  input  logic [85:0]      cp0_tlb_conf_out,
  input  logic             miss_probe,
  input  logic [IDX_W-1:0] matched_index_probe
);

  tlb_fsm_e         state, state_nxt;
  logic             index_p;
  logic [IDX_W-1:0] index_idx;
  logic [25:0]      entrylo0, entrylo1;
  logic [18:0]      entryhi_vpn2;
  logic [7:0]       entryhi_asid;
  logic [31:0]      badvaddr;
  logic [IDX_W-1:0] wired;
  tlb_entry_t       conf_rd, conf_wr;
  logic [7:0]       unused_pad;

  assign conf_rd    = cp0_tlb_conf_out;
  assign unused_pad = conf_rd.pad;

  function automatic logic wr_hit(input logic [4:0] addr);
    return mtc0_en && (mtc0_addr == addr);
  endfunction

  cp0_random_counter #(
    .IDX_W        (IDX_W),
    .RANDOM_RESET (RANDOM_RESET)
  ) u_random (
    .clk         (clk),
    .rst         (rst),
    .wired_we    (wr_hit(CP0_WIRED)),
    .wired_wdata (mtc0_data[IDX_W-1:0]),
    .wired       (wired),
    .random      (cp0_random)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // done/tlbp are masked during reset so an aborted sequence never commits
  always_comb begin
    state_nxt = state;
    tlbp      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tlbp_req) begin
          tlbp      = !rst;
          state_nxt = ST_PROBE;
        end else if (tlbr_req) begin
          state_nxt = ST_READ;
        end
      end
      ST_PROBE, ST_READ: begin
        done      = !rst;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy  = (state != ST_IDLE);
  assign tlbwi = tlbwi_req;
  assign tlbwr = tlbwr_req;

  // Per register: exception load beats sequencer capture beats software write
  always_ff @(posedge clk) begin
    if (rst) begin
      index_p      <= 1'b0;
      index_idx    <= '0;
      entrylo0     <= '0;
      entrylo1     <= '0;
      entryhi_vpn2 <= '0;
      entryhi_asid <= '0;
      badvaddr     <= '0;
    end else begin
      if (state == ST_PROBE) begin
        index_p <= miss_probe;
        if (!miss_probe) index_idx <= matched_index_probe;
      end else if (wr_hit(CP0_INDEX)) begin
        index_p   <= mtc0_data[31];
        index_idx <= mtc0_data[IDX_W-1:0];
      end

      if (state == ST_READ)         entrylo0 <= {conf_rd.p0, conf_rd.g};
      else if (wr_hit(CP0_ENTRYLO0)) entrylo0 <= mtc0_data[25:0];

      if (state == ST_READ)         entrylo1 <= {conf_rd.p1, conf_rd.g};
      else if (wr_hit(CP0_ENTRYLO1)) entrylo1 <= mtc0_data[25:0];

      if (tlb_exc) begin
        entryhi_vpn2 <= tlb_exc_vaddr[31:13];
      end else if (state == ST_READ) begin
        entryhi_vpn2 <= conf_rd.vpn2;
        entryhi_asid <= conf_rd.asid;
      end else if (wr_hit(CP0_ENTRYHI)) begin
        entryhi_vpn2 <= mtc0_data[31:13];
        entryhi_asid <= mtc0_data[7:0];
      end

      if (tlb_exc)                  badvaddr <= tlb_exc_vaddr;
      else if (wr_hit(CP0_BADVADDR)) badvaddr <= mtc0_data;
    end
  end

  always_comb begin
    conf_wr      = '0;
    conf_wr.vpn2 = entryhi_vpn2;
    conf_wr.asid = entryhi_asid;
    conf_wr.g    = entrylo0[0] & entrylo1[0];
    conf_wr.p0   = entrylo0[25:1];
    conf_wr.p1   = entrylo1[25:1];
  end

  assign cp0_tlb_conf_in = conf_wr;
  assign cp0_index       = index_idx;
  assign curr_ASID       = entryhi_asid;

  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
      CP0_INDEX:    mfc0_data = {index_p, {(31-IDX_W){1'b0}}, index_idx};
      CP0_RANDOM:   mfc0_data = {{(32-IDX_W){1'b0}}, cp0_random};
      CP0_ENTRYLO0: mfc0_data = {6'b0, entrylo0};
      CP0_ENTRYLO1: mfc0_data = {6'b0, entrylo1};
      CP0_WIRED:    mfc0_data = {{(32-IDX_W){1'b0}}, wired};
      CP0_BADVADDR: mfc0_data = badvaddr;
      CP0_ENTRYHI:  mfc0_data = {entryhi_vpn2, 5'b0, entryhi_asid};
      default:      mfc0_data = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_tlb_regs.sv
// Bench for cp0_tlb_regs: directed scenarios then random traffic, all checked
// against a register-level reference model; the bench also plays the TLB array.
module tb_cp0_tlb_regs;

  logic        clk = 1'b0;
  logic        rst, mtc0_en, tlbp_req, tlbr_req, tlbwi_req, tlbwr_req, tlb_exc, miss_probe;
  logic [4:0]  mtc0_addr, mfc0_addr;
  logic [31:0] mtc0_data, mfc0_data, tlb_exc_vaddr;
  logic        busy, done, tlbp, tlbwi, tlbwr;
  logic [7:0]  curr_ASID;
  logic [3:0]  cp0_index, cp0_random, matched_index_probe;
  logic [85:0] cp0_tlb_conf_in, cp0_tlb_conf_out;
  logic [85:0] tlb_mem [16];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_p;
  logic [3:0]  m_idx, m_wired;
  logic [25:0] m_lo0, m_lo1;
  logic [18:0] m_vpn2;
  logic [7:0]  m_asid;
  logic [31:0] m_badv;
  int          m_t, m_pend;  // m_t: edges since Random last reloaded; m_pend: 0 none, 1 probe, 2 read

  always #10 clk = ~clk;

  assign cp0_tlb_conf_out = tlb_mem[cp0_index];

  cp0_tlb_regs dut (
    .clk(clk), .rst(rst), .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data), .tlbp_req(tlbp_req), .tlbr_req(tlbr_req),
    .tlbwi_req(tlbwi_req), .tlbwr_req(tlbwr_req), .busy(busy), .done(done), .tlb_exc(tlb_exc),
    .tlb_exc_vaddr(tlb_exc_vaddr), .tlbp(tlbp), .tlbwi(tlbwi), .tlbwr(tlbwr), .curr_ASID(curr_ASID),
    .cp0_index(cp0_index), .cp0_random(cp0_random), .cp0_tlb_conf_in(cp0_tlb_conf_in),
    .cp0_tlb_conf_out(cp0_tlb_conf_out), .miss_probe(miss_probe), .matched_index_probe(matched_index_probe)
  );

  task automatic check(input string tag, input logic [85:0] obs, input logic [85:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Random cycles through RANDOM_RESET down to Wired, a period of 16-Wired edges
  function automatic logic [3:0] m_random();
    return 4'(15 - (m_t % (16 - int'(m_wired))));
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    case (a)
      5'd0:    return {m_p, 27'b0, m_idx};
      5'd1:    return {28'b0, m_random()};
      5'd2:    return {6'b0, m_lo0};
      5'd3:    return {6'b0, m_lo1};
      5'd6:    return {28'b0, m_wired};
      5'd8:    return m_badv;
      5'd10:   return {m_vpn2, 5'b0, m_asid};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [85:0] e;
    logic        wr;
    e  = tlb_mem[m_idx];
    wr = mtc0_en;
    if (rst) begin
      m_p = 0; m_idx = 0; m_lo0 = 0; m_lo1 = 0; m_vpn2 = 0; m_asid = 0;
      m_badv = 0; m_wired = 0; m_t = 0; m_pend = 0;
    end else begin
      if (m_pend == 1) begin
        m_p = miss_probe;
        if (!miss_probe) m_idx = matched_index_probe;
      end else if (wr && mtc0_addr == 5'd0) begin
        m_p = mtc0_data[31]; m_idx = mtc0_data[3:0];
      end
      if (m_pend == 2) m_lo0 = {e[57:33], e[58]};
      else if (wr && mtc0_addr == 5'd2) m_lo0 = mtc0_data[25:0];
      if (m_pend == 2) m_lo1 = {e[32:8], e[58]};
      else if (wr && mtc0_addr == 5'd3) m_lo1 = mtc0_data[25:0];
      if (tlb_exc) m_vpn2 = tlb_exc_vaddr[31:13];
      else if (m_pend == 2) begin m_vpn2 = e[85:67]; m_asid = e[66:59]; end
      else if (wr && mtc0_addr == 5'd10) begin m_vpn2 = mtc0_data[31:13]; m_asid = mtc0_data[7:0]; end
      if (tlb_exc) m_badv = tlb_exc_vaddr;
      else if (wr && mtc0_addr == 5'd8) m_badv = mtc0_data;
      if (wr && mtc0_addr == 5'd6) begin m_wired = mtc0_data[3:0]; m_t = 0; end
      else m_t++;
      if (m_pend != 0) m_pend = 0;
      else if (tlbp_req) m_pend = 1;
      else if (tlbr_req) m_pend = 2;
    end
  endtask

  task automatic clear_inputs();
    rst = 0; mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0; tlbp_req = 0; tlbr_req = 0;
    tlbwi_req = 0; tlbwr_req = 0; tlb_exc = 0; tlb_exc_vaddr = 0;
  endtask

  // Check combinational outputs, advance one edge, then check all state
  task automatic tick(input bit chk_pre);
    logic [4:0] addrs [8];
    #1;
    if (chk_pre) begin
      check("busy", 86'(busy), 86'(m_pend != 0));
      check("done", 86'(done), 86'(m_pend != 0 && !rst));
      check("tlbp", 86'(tlbp), 86'(m_pend == 0 && tlbp_req && !rst));
      check("tlbwi", 86'(tlbwi), 86'(tlbwi_req));
      check("tlbwr", 86'(tlbwr), 86'(tlbwr_req));
    end
    model_edge();
    @(posedge clk);
    #1;
    clear_inputs();
    check("cp0_index", 86'(cp0_index), 86'(m_idx));
    check("cp0_random", 86'(cp0_random), 86'(m_random()));
    check("curr_ASID", 86'(curr_ASID), 86'(m_asid));
    check("conf_in", cp0_tlb_conf_in,
          {m_vpn2, m_asid, m_lo0[0] & m_lo1[0], m_lo0[25:1], m_lo1[25:1], 8'h00});
    addrs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd8, 5'd10, 5'($urandom_range(11, 31))};
    foreach (addrs[i]) begin
      mfc0_addr = addrs[i];
      #1;
      check($sformatf("mfc0[%0d]", addrs[i]), 86'(mfc0_data), 86'(exp_rd(addrs[i])));
    end
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1;
    check(tag, 86'(mfc0_data), 86'(exp));
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    mtc0_en = 1; mtc0_addr = a; mtc0_data = d;
    tick(1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tlb_mem[i] = 86'({$urandom(), $urandom(), $urandom()});
    clear_inputs();
    mfc0_addr = 0; miss_probe = 0; matched_index_probe = 0;
    m_pend = 0; m_t = 0;

    rst = 1;
    tick(0);
    check("reset_random", 86'(cp0_random), 86'(15));

    // Free-running Random with Wired = 0
    for (int i = 0; i < 15; i++) tick(1);
    check("random_at_0", 86'(cp0_random), 86'(0));
    tick(1);
    check("random_wrap", 86'(cp0_random), 86'(15));
    for (int i = 0; i < 4; i++) tick(1);

    // Wired = 4: reload immediately, count to 4, wrap
    mtc0(5'd6, 32'd4);
    check("wired_reload", 86'(cp0_random), 86'(15));
    for (int i = 0; i < 11; i++) tick(1);
    check("random_at_wired", 86'(cp0_random), 86'(4));
    tick(1);
    check("random_wrap_wired", 86'(cp0_random), 86'(15));
    mtc0(5'd1, 32'd2);

    // TLBP hit at index 7
    mtc0(5'd10, 32'h0040_2005);
    matched_index_probe = 4'd7; miss_probe = 0; tlbp_req = 1;
    tick(1);
    tick(1);
    rd_check("probe_hit_index", 5'd0, 32'h0000_0007);
    tick(1);

    // TLBP miss keeps the old index and sets P
    mtc0(5'd0, 32'd3);
    miss_probe = 1; matched_index_probe = 4'd9; tlbp_req = 1;
    tick(1);
    tick(1);
    rd_check("probe_miss_index", 5'd0, 32'h8000_0003);
    miss_probe = 0;

    // TLBR of entry 5
    tlb_mem[5] = {19'h201, 8'h05, 1'b1, 20'h123, 3'd3, 1'b1, 1'b1, 25'h0, 8'h00};
    mtc0(5'd0, 32'd5);
    tlbr_req = 1;
    tick(1);
    tick(1);
    rd_check("tlbr_entryhi", 5'd10, 32'h0040_2005);
    rd_check("tlbr_entrylo0", 5'd2, 32'h0000_48DF);

    // Exception load beats a same-cycle EntryHi write
    tlb_exc = 1; tlb_exc_vaddr = 32'hDEAD_B000;
    mtc0(5'd10, 32'h1234_5678);
    rd_check("exc_entryhi", 5'd10, 32'hDEAD_A005);
    rd_check("exc_badvaddr", 5'd8, 32'hDEAD_B000);

    // TLBP and TLBR together: probe wins
    tlbp_req = 1; tlbr_req = 1; matched_index_probe = 4'd2;
    tick(1);
    tick(1);

    // Reset during a probe: no done pulse
    tlbp_req = 1;
    tick(1);
    rst = 1;
    tick(1);
    tick(1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] pool [10];
      pool = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd6, 5'd8, 5'd10, 5'd4, 5'd7, 5'd12};
      rst                 = ($urandom_range(0, 63) == 0);
      mtc0_en             = ($urandom_range(0, 2) == 0);
      mtc0_addr           = pool[$urandom_range(0, 9)];
      mtc0_data           = $urandom();
      tlbp_req            = ($urandom_range(0, 3) == 0);
      tlbr_req            = ($urandom_range(0, 3) == 0);
      tlbwi_req           = 1'($urandom_range(0, 1));
      tlbwr_req           = 1'($urandom_range(0, 1));
      tlb_exc             = ($urandom_range(0, 7) == 0);
      tlb_exc_vaddr       = $urandom();
      miss_probe          = 1'($urandom_range(0, 1));
      matched_index_probe = 4'($urandom_range(0, 15));
      tick(1);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
